main_onchip_memory_arbiter: RTL

Two-master arbiter that shares the single-port on-chip memory (32-bit data, 15-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM style requesters, e.g. the CPU data master and the GCD accelerator DMA.
- Round-robin, one command per cycle, fully pipelined reads.
- A halt handshake drains the in-flight read and then gates the memory clock enable, for safe system quiesce/reset.

---
 rtl/main_onchip_memory_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/main_onchip_memory_arbiter.sv
// rtl/main_onchip_memory_arbiter.sv - round-robin two-master arbiter for the single-port on-chip memory
// A halt handshake drains the pending read and then gates the memory clock enable.
module main_onchip_memory_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  halt_req,
  output logic                  halt_ack
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctl_state_e;

  ctl_state_e ctl_state_q, ctl_state_d;
  logic       prio_q, prio_d;
  logic       rd_pend_valid_q, rd_pend_valid_d;
  logic       rd_pend_id_q, rd_pend_id_d;

  logic run;
  logic m0_req, m1_req;
  logic gnt0, gnt1;
  logic gnt_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_state_q     <= RUN;
      prio_q          <= 1'b0;
      rd_pend_valid_q <= 1'b0;
      rd_pend_id_q    <= 1'b0;
    end else begin
      ctl_state_q     <= ctl_state_d;
      prio_q          <= prio_d;
      rd_pend_valid_q <= rd_pend_valid_d;
      rd_pend_id_q    <= rd_pend_id_d;
    end
  end

  always_comb begin
    ctl_state_d = ctl_state_q;
    unique case (ctl_state_q)
      RUN:     ctl_state_d = halt_req ? DRAIN : RUN;
      DRAIN:   ctl_state_d = halt_req ? HALTED : RUN;
      HALTED:  ctl_state_d = halt_req ? HALTED : RUN;
      default: ctl_state_d = RUN;
    endcase
  end

  always_comb begin
    // Reset masks the outputs combinationally so nothing escapes before the state settles.
    run    = (ctl_state_q == RUN) && !reset;
    m0_req = m0_read | m0_write;
    m1_req = m1_read | m1_write;
    gnt0   = run & m0_req & (~m1_req | ~prio_q);
    gnt1   = run & m1_req & (~m0_req | prio_q);

    m0_waitrequest = ~gnt0 & (m0_req | ~run);
    m1_waitrequest = ~gnt1 & (m1_req | ~run);

    mem_chipselect = gnt0 | gnt1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    gnt_read       = 1'b0;
    if (gnt0) begin
      mem_write      = m0_write;
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      gnt_read       = ~m0_write;
    end else if (gnt1) begin
      mem_write      = m1_write;
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      gnt_read       = ~m1_write;
    end

    prio_d = prio_q;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
    rd_pend_valid_d = gnt_read;
    rd_pend_id_d    = gnt1;

    m0_readdatavalid = rd_pend_valid_q & ~rd_pend_id_q & ~reset;
    m1_readdatavalid = rd_pend_valid_q & rd_pend_id_q & ~reset;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;

    halt_ack  = (ctl_state_q == HALTED) && !reset;
    mem_clken = (ctl_state_q != HALTED) || reset;
  end

endmodule
